// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-slot alarm scheduler.
package alarm_pkg;

    typedef logic [23:0] bcd_time_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam logic [7:0] VOL_OFF = 8'h00;

    // True when every digit is decimal and HH <= 23, MM <= 59, SS <= 59.
    function automatic logic bcd_time_valid(input bcd_time_t t);
        return (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23) &&
               (t[15:12] <= 4'd5) && (t[11:8]  <= 4'd9) &&
               (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9);
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored BCD time, arm flag, write port and match compare.
module alarm_slot
    import alarm_pkg::*;
(
    input  logic      CLK,
    input  logic      reset,
    input  logic      i_wr,
    input  bcd_time_t i_wr_time,
    input  logic      i_wr_arm,
    input  logic      i_clr,
    input  bcd_time_t i_time_now,
    output logic      o_match,
    output logic      o_armed
);

    bcd_time_t r_time;
    logic      r_armed;

    // A write in the same cycle as an FSM disarm wins: the host's intent is newest.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_time  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (i_clr)
                r_armed <= 1'b0;
            if (i_wr) begin
                r_time  <= i_wr_time;
                r_armed <= i_wr_arm;
            end
        end
    end

    assign o_match = r_armed && (r_time == i_time_now) && bcd_time_valid(r_time);
    assign o_armed = r_armed;

endmodule

// File: rtl/alarm_scheduler.sv
// N-slot alarm controller: match arbitration, ring/snooze/timeout sequencing.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int         N_ALARMS    = 4,
    parameter int         TIMEOUT_SEC = 300,
    parameter int         SNOOZE_SEC  = 540,
    parameter logic [7:0] VOL_ON      = 8'h80
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        tick_1hz,
    input  logic [23:0]                 time_now,
    input  logic                        wr_en,
    input  logic [$clog2(N_ALARMS)-1:0] wr_idx,
    input  logic [23:0]                 wr_time,
    input  logic                        wr_arm,
    input  logic                        dismiss,
    input  logic                        snooze,
    output logic [7:0]                  vol,
    output logic                        ringing,
    output logic [$clog2(N_ALARMS)-1:0] ring_idx,
    output logic [N_ALARMS-1:0]         armed
);

    localparam int IDX_W = $clog2(N_ALARMS);
`ifdef ALARM_SNOOZE_EN
    localparam int CNT_MAX = (TIMEOUT_SEC > SNOOZE_SEC) ? TIMEOUT_SEC : SNOOZE_SEC;
`else
    localparam int CNT_MAX = TIMEOUT_SEC;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    alarm_state_t      r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [IDX_W-1:0]  r_ring_idx, w_idx_nxt, w_win;
    logic [7:0]        r_vol;
    logic              r_ringing;
    logic              w_any, w_clr, w_disarm_ring;
    logic [N_ALARMS-1:0] w_match, w_armed;

    genvar g;
    generate
        for (g = 0; g < N_ALARMS; g++) begin : g_slot
            alarm_slot u_slot (
                .CLK        (CLK),
                .reset      (reset),
                .i_wr       (wr_en && (wr_idx == IDX_W'(g))),
                .i_wr_time  (wr_time),
                .i_wr_arm   (wr_arm),
                .i_clr      (w_clr && (r_ring_idx == IDX_W'(g))),
                .i_time_now (time_now),
                .o_match    (w_match[g]),
                .o_armed    (w_armed[g])
            );
        end
    endgenerate

    // Lowest index wins among simultaneous matches.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_any = 1'b1;
                w_win = IDX_W'(i);
            end
        end
    end

    assign w_cnt_inc     = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_disarm_ring = wr_en && !wr_arm && (wr_idx == r_ring_idx) && (r_state != IDLE);

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SN_LAST = CNT_W'(SNOOZE_SEC - 1);
`else
    logic w_unused;
    assign w_unused = &{1'b0, snooze, SNOOZE_SEC[0]};
`endif

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_ring_idx;
        w_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (tick_1hz && w_any) begin
                    w_next    = RING;
                    w_idx_nxt = w_win;
                    w_cnt_nxt = '0;
                end
            end
            RING: begin
                if (dismiss) begin
                    w_clr  = 1'b1;
                    w_next = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    w_cnt_nxt = '0;
                    w_next    = SNOOZE;
`endif
                end else if (tick_1hz) begin
                    if (r_cnt >= TO_LAST) begin
                        w_clr     = 1'b1;
                        w_cnt_nxt = '0;
                        w_next    = IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (dismiss) begin
                    w_clr  = 1'b1;
                    w_next = IDLE;
                end else if (tick_1hz) begin
                    if (r_cnt >= SN_LAST) begin
                        w_cnt_nxt = '0;
                        w_next    = RING;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
`endif
            default: w_next = IDLE;
        endcase
        // Host disarming the active slot aborts the ring outright.
        if (w_disarm_ring)
            w_next = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ring_idx <= '0;
            r_vol      <= VOL_OFF;
            r_ringing  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
            r_ring_idx <= w_idx_nxt;
            r_vol      <= (w_next == RING) ? VOL_ON : VOL_OFF;
            r_ringing  <= (w_next != IDLE);
        end
    end

    assign vol      = r_vol;
    assign ringing  = r_ringing;
    assign ring_idx = r_ring_idx;
    assign armed    = w_armed;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Randomized + directed bench for alarm_scheduler against a behavioural model.
module tb_alarm_scheduler;

    localparam int TB_TO = 5;
    localparam int TB_SN = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0;
    logic [23:0] time_now = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [23:0] wr_time = '0;
    logic        wr_arm = 1'b0;
    logic        dismiss = 1'b0;
    logic        snooze = 1'b0;
    logic [7:0]  vol;
    logic        ringing;
    logic [1:0]  ring_idx;
    logic [3:0]  armed;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    alarm_scheduler #(.N_ALARMS(4), .TIMEOUT_SEC(TB_TO), .SNOOZE_SEC(TB_SN), .VOL_ON(8'h80)) dut (
        .CLK(CLK), .reset(reset), .tick_1hz(tick_1hz), .time_now(time_now),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_arm(wr_arm),
        .dismiss(dismiss), .snooze(snooze), .vol(vol), .ringing(ringing),
        .ring_idx(ring_idx), .armed(armed)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [23:0] m_time [4];
    bit [3:0]  m_arm;
    int        m_st;   // 0 idle, 1 ringing, 2 snoozed
    int        m_cnt, m_idx;

    function automatic bit valid_time(input bit [23:0] t);
        int d [6];
        for (int k = 0; k < 6; k++) begin
            d[k] = int'((t >> (4 * k)) & 24'hF);
            if (d[k] > 9) return 1'b0;
        end
        return (d[5] * 10 + d[4] < 24) && (d[3] * 10 + d[2] < 60) && (d[1] * 10 + d[0] < 60);
    endfunction

    always @(posedge CLK) begin
        int nst, ncnt, nidx, win;
        bit clr;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_time[i] = '0;
            m_arm = '0; m_st = 0; m_cnt = 0; m_idx = 0;
        end else begin
            nst = m_st; ncnt = m_cnt; nidx = m_idx; win = -1; clr = 1'b0;
            if (tick_1hz)
                for (int i = 0; i < 4; i++)
                    if (win < 0 && m_arm[i] && m_time[i] == time_now && valid_time(m_time[i])) win = i;
            if (m_st == 0) begin
                if (win >= 0) begin nst = 1; nidx = win; ncnt = 0; end
            end else if (dismiss) begin
                clr = 1'b1; nst = 0;
            end else if (m_st == 1 && SNZ && snooze) begin
                nst = 2; ncnt = 0;
            end else if (tick_1hz) begin
                ncnt = m_cnt + 1;
                if (m_st == 1 && ncnt >= TB_TO) begin clr = 1'b1; nst = 0; ncnt = 0; end
                else if (m_st == 2 && ncnt >= TB_SN) begin nst = 1; ncnt = 0; end
            end
            if (m_st != 0 && wr_en && !wr_arm && int'(wr_idx) == m_idx) nst = 0;
            if (clr) m_arm[m_idx] = 1'b0;
            if (wr_en) begin m_time[wr_idx] = wr_time; m_arm[wr_idx] = wr_arm; end
            m_st = nst; m_cnt = ncnt; m_idx = nidx;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("vol",      int'(vol),      (m_st == 1) ? 'h80 : 0);
            check("ringing",  int'(ringing),  (m_st != 0) ? 1 : 0);
            check("ring_idx", int'(ring_idx), m_idx);
            check("armed",    int'(armed),    int'(m_arm));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
        tick_1hz = 1'b0; wr_en = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    endtask

    task automatic wr(input int idx, input bit [23:0] t, input bit arm);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_time = t; wr_arm = arm;
        cyc();
    endtask

    task automatic tk(input bit [23:0] t);
        time_now = t; tick_1hz = 1'b1;
        cyc();
    endtask

    bit [23:0] pool [4];

    initial begin
        pool[0] = 24'h070000; pool[1] = 24'h063000; pool[2] = 24'h235959; pool[3] = 24'h0A0000;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_vol", int'(vol), 0);
        check("rst_ringing", int'(ringing), 0);
        check("rst_ring_idx", int'(ring_idx), 0);
        check("rst_armed", int'(armed), 0);

        // single alarm on slot 1
        wr(1, 24'h070000, 1'b1);
        check("wr_armed", int'(armed), 'b0010);
        tk(24'h070000);
        check("t1_ringing", int'(ringing), 1);
        check("t1_idx", int'(ring_idx), 1);
        check("t1_vol", int'(vol), 'h80);
        check("t1_model_vol", (m_st == 1) ? 'h80 : 0, 'h80);
        dismiss = 1'b1; cyc();
        check("t1_dismiss_ring", int'(ringing), 0);
        check("t1_dismiss_armed", int'(armed), 0);

        // two slots match: lowest wins, other dropped
        wr(0, 24'h063000, 1'b1);
        wr(2, 24'h063000, 1'b1);
        tk(24'h063000);
        check("t2_idx", int'(ring_idx), 0);
        check("t2_ringing", int'(ringing), 1);
        dismiss = 1'b1; cyc();
        check("t2_armed", int'(armed), 'b0100);
        tk(24'h063001);
        check("t2_no_requeue", int'(ringing), 0);

        // timeout after 5 ticks
        wr(3, 24'h080000, 1'b1);
        tk(24'h080000);
        for (int s = 1; s <= 4; s++) tk(24'h080000 + 24'(s));
        check("t3_before_to", int'(ringing), 1);
        tk(24'h080005);
        check("t3_to_ringing", int'(ringing), 0);
        check("t3_to_vol", int'(vol), 0);
        check("t3_to_armed", int'(armed), 'b0100);

        if (SNZ) begin
            wr(1, 24'h090000, 1'b1);
            tk(24'h090000);
            snooze = 1'b1; cyc();
            check("t4_snz_vol", int'(vol), 0);
            check("t4_snz_ring", int'(ringing), 1);
            tk(24'h090001); tk(24'h090002);
            check("t4_snz_still", int'(vol), 0);
            tk(24'h090003);
            check("t4_snz_back", int'(vol), 'h80);
            dismiss = 1'b1; snooze = 1'b1; cyc();
            check("t4_dis_snz", int'(ringing), 0);
        end

        // non-BCD slot never matches
        wr(1, 24'h0A0000, 1'b1);
        tk(24'h0A0000);
        check("t5_nonbcd", int'(ringing), 0);

        // disarm-write of ringing slot, then reset mid-ring
        wr(0, 24'h100000, 1'b1);
        tk(24'h100000);
        check("t6_ring", int'(ringing), 1);
        wr(0, 24'h100000, 1'b0);
        check("t6_disarm", int'(ringing), 0);
        wr(0, 24'h110000, 1'b1);
        tk(24'h110000);
        check("t6_ring2", int'(ringing), 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("t6_rst_ring", int'(ringing), 0);
        check("t6_rst_vol", int'(vol), 0);
        check("t6_rst_armed", int'(armed), 0);

        // randomized phase
        for (int n = 0; n < 4000; n++) begin
            reset    = ($urandom_range(0, 499) == 0);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_idx   = 2'($urandom_range(0, 3));
            wr_time  = pool[$urandom_range(0, 3)];
            wr_arm   = ($urandom_range(0, 3) != 0);
            time_now = pool[$urandom_range(0, 3)];
            tick_1hz = ($urandom_range(0, 2) == 0);
            dismiss  = ($urandom_range(0, 24) == 0);
            snooze   = ($urandom_range(0, 11) == 0);
            cyc();
        end
        reset = 1'b0;
        cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm controller for the 24-hour alarm clock. It holds N programmable BCD alarm times and compares them against the running clock once per second. It arbitrates which armed alarm rings, and sequences the ring, snooze and timeout behaviour. It drives the 8-bit volume input of the audio tone generator and the alarm status LED, replacing the single-alarm control logic in the top level.

## Interface
Parameters:
- N_ALARMS, 4: number of alarm slots (2..8).
- TIMEOUT_SEC, 300: seconds of continuous ringing before auto-dismiss.
- SNOOZE_SEC, 540: snooze duration in seconds.
- VOL_ON, 8'h80: volume value driven while ringing.

Ports:
- CLK  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  single-CLK pulse once per second; time_now is valid in that cycle.
- time_now  in  24  current time, packed BCD HHMMSS.
- wr_en  in  1  slot write strobe.
- wr_idx  in  clog2(N_ALARMS)  slot to write.
- wr_time  in  24  BCD alarm time to store.
- wr_arm  in  1  arm flag to store with wr_time.
- dismiss  in  1  single-cycle pulse: stop the active alarm.
- snooze  in  1  single-cycle pulse: snooze the active alarm.
- vol  out  8  audio volume.
- ringing  out  1  alarm status LED.
- ring_idx  out  clog2(N_ALARMS)  slot currently ringing or snoozed.
- armed  out  N_ALARMS  per-slot arm flags.

## Operation
- Reset values: all slot times 24'h000000, armed=0, state IDLE, vol=0, ringing=0, ring_idx=0, sec counter=0.
- Slot write: when wr_en=1, slot[wr_idx] takes wr_time and armed[wr_idx] takes wr_arm. The write is accepted in any state.
- Writing wr_arm=0 to the ringing or snoozed slot forces IDLE.
- FSM states and transitions:
  - IDLE:
    - On tick_1hz, the match set is all armed slots with time == time_now.
    - If the match set is non-empty, the lowest index wins: ring_idx is latched, counter cleared, go to RING.
  - RING:
    - vol=VOL_ON, ringing=1.
    - Each tick_1hz increments counter.
    - When counter reaches TIMEOUT_SEC, clear armed[ring_idx] and go to IDLE.
    - dismiss: clear armed[ring_idx], go to IDLE.
    - snooze: counter cleared, go to SNOOZE.
  - SNOOZE:
    - vol=0, ringing=1.
    - Each tick increments counter.
    - When counter reaches SNOOZE_SEC, counter is cleared and the FSM returns to RING.
    - dismiss: clear armed[ring_idx], go to IDLE.
- Matches from other slots during RING or SNOOZE are dropped. They are not queued, and those slots stay armed for the next day.
- Priority within a cycle: reset > dismiss > snooze > timeout/snooze expiry > match.
- The comparison uses the slot contents from before any same-cycle write.
- Stored times are not range-checked. A slot holding non-BCD or out-of-range values never matches.
- Counter width is clog2(max(TIMEOUT_SEC, SNOOZE_SEC)+1). The counter saturates and never wraps.

## Timing
- A match on a tick cycle gives state, vol and ringing updated on the next CLK edge: 1-cycle latency.
- dismiss/snooze take effect on the next edge. vol=0 one cycle after the pulse.
- Timeout: ringing drops on the edge after the TIMEOUT_SEC-th tick counted in RING.
- All outputs are registered. There are no combinational input-to-output paths.
- Reset asserted mid-ring clears vol and ringing on the next edge, and all slots are disarmed.

## Configuration
- ALARM_SNOOZE_EN defined:
  - SNOOZE state, the snooze input and the SNOOZE_SEC logic are present.
- ALARM_SNOOZE_EN undefined:
  - The snooze port still exists but is ignored, and there is no SNOOZE state.
  - RING exits only via dismiss, timeout, disarm-write or reset.
  - The counter is sized from TIMEOUT_SEC only.

## Structure
- Package alarm_pkg:
  - bcd_time_t (24-bit packed HHMMSS).
  - State enum {IDLE, RING, SNOOZE}.
  - VOL_OFF=8'h00.
- Sub-module alarm_slot: holds one slot's time register and arm flag, and provides the write port and equality compare with time_now (output match).
- The top instantiates N_ALARMS slots, a lowest-index priority encoder, the FSM and the second counter.

## Test plan
Bench uses TIMEOUT_SEC=5, SNOOZE_SEC=3.
- Write slot1=24'h070000 armed, drive time_now=24'h070000 with tick: ringing=1, ring_idx=1, vol=8'h80 one cycle later.
- Slots 0 and 2 both 24'h063000 armed, matching tick: ring_idx=0. After dismiss, armed=4'b0100 and slot 2 does not ring at that time.
- Ring with no input for 5 ticks: ringing=0 and vol=0 after the 5th tick, armed[idx]=0.
- (ALARM_SNOOZE_EN) snooze during RING: vol=0 and ringing=1 next cycle, vol=8'h80 again after 3 ticks. Dismiss and snooze in the same cycle gives IDLE.
- Write slot 0 with wr_arm=0 while it rings gives IDLE next cycle. Reset asserted while ringing clears all outputs and armed=0.
